// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit that owns HI/LO.
// Define MDU_HILO_WRITE_EN to add the hi_we/lo_we/wdata write port for MTHI/MTLO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MDU_HILO_WRITE_EN
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, MUL_ITER, DIV_ITER, DIV_FIX, DONE} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH:0]   acc_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic             qm1_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_acc_next;
    logic [WIDTH-1:0] booth_q_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH:0]   div_acc_next;
    logic [WIDTH-1:0] div_q_next;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             last_iter;

    always_comb begin
        a_mag     = a[WIDTH-1] ? -a : a;
        b_mag     = b[WIDTH-1] ? -b : b;
        last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

        // Accumulator carries one guard bit so that subtracting -2^(WIDTH-1) cannot overflow.
        m_ext     = {m_reg[WIDTH-1], m_reg};
        booth_sum = acc_reg;
        case ({q_reg[0], qm1_reg})
            2'b01:   booth_sum = acc_reg + m_ext;
            2'b10:   booth_sum = acc_reg - m_ext;
            default: booth_sum = acc_reg;
        endcase
        booth_acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_q_next   = {booth_sum[0], q_reg[WIDTH-1:1]};

        div_shift    = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        div_ge       = (div_shift >= {1'b0, m_reg});
        div_diff     = div_shift - {1'b0, m_reg};
        div_acc_next = div_ge ? div_diff : div_shift;
        div_q_next   = {q_reg[WIDTH-2:0], div_ge};

        quot_fix = neg_q_reg ? -q_reg : q_reg;
        rem_fix  = neg_r_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            qm1_reg   <= 1'b0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (start_mult) begin
                        acc_reg   <= '0;
                        q_reg     <= b;
                        m_reg     <= a;
                        qm1_reg   <= 1'b0;
                        div_zero  <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= MUL_ITER;
                    end else if (start_div) begin
                        div_zero <= (b == '0);
                        if (b == '0) begin
                            // Zero divisor: skip straight to the done pulse, leaving HI/LO untouched.
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            acc_reg   <= '0;
                            q_reg     <= a_mag;
                            m_reg     <= b_mag;
                            neg_q_reg <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r_reg <= a[WIDTH-1];
                            busy      <= 1'b1;
                            state_reg <= DIV_ITER;
                        end
                    end
`ifdef MDU_HILO_WRITE_EN
                    else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
`endif
                end
                MUL_ITER: begin
                    acc_reg <= booth_acc_next;
                    q_reg   <= booth_q_next;
                    qm1_reg <= q_reg[0];
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (last_iter) begin
                        hi        <= booth_acc_next[WIDTH-1:0];
                        lo        <= booth_q_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DIV_ITER: begin
                    acc_reg <= div_acc_next;
                    q_reg   <= div_q_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (last_iter) state_reg <= DIV_FIX;
                end
                DIV_FIX: begin
                    hi        <= rem_fix;
                    lo        <= quot_fix;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic HI/LO model.
// Exercises the hi_we/lo_we/wdata port when MDU_HILO_WRITE_EN is defined.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;
`ifdef MDU_HILO_WRITE_EN
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
`endif

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
`ifdef MDU_HILO_WRITE_EN
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .wdata      (wdata),
`endif
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        exp_dz = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: full 64-bit signed product; truncating signed divide on 64-bit ints.
    task automatic model_op(input bit is_div, input logic [31:0] oa, input logic [31:0] ob,
                            output int lat);
        longint p, sa, sb, q, r;
        sa = longint'($signed(oa));
        sb = longint'($signed(ob));
        if (!is_div) begin
            p = sa * sb;
            exp_hi = p[63:32];
            exp_lo = p[31:0];
            exp_dz = 1'b0;
            lat = 32;
        end else if (ob == 32'd0) begin
            exp_dz = 1'b1;
            lat = 0;
        end else begin
            q = sa / sb;
            r = sa % sb;
            exp_lo = q[31:0];
            exp_hi = r[31:0];
            exp_dz = 1'b0;
            lat = 33;
        end
    endtask

    task automatic do_op(input bit is_div, input logic [31:0] oa, input logic [31:0] ob,
                         input int pulse_k);
        int lat_exp, lat_obs, busy_cnt;
        logic [31:0] prev_hi, prev_lo;
        prev_hi = exp_hi;
        prev_lo = exp_lo;
        @(negedge clk);
        a = oa;
        b = ob;
        start_mult = !is_div;
        start_div  = is_div;
        model_op(is_div, oa, ob, lat_exp);
        @(posedge clk); #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a = $urandom;
        b = $urandom;
        busy_cnt = 0;
        lat_obs = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                lat_obs = k;
                break;
            end
            if (k == pulse_k + 1) begin
                check("hold_hi", hi, prev_hi);
                check("hold_lo", lo, prev_lo);
            end
            if (busy) busy_cnt++;
            start_div = (k == pulse_k);
`ifdef MDU_HILO_WRITE_EN
            hi_we = (k == pulse_k);
            lo_we = (k == pulse_k);
            wdata = $urandom;
`endif
            @(posedge clk); #1;
        end
        start_div = 1'b0;
`ifdef MDU_HILO_WRITE_EN
        hi_we = 1'b0;
        lo_we = 1'b0;
`endif
        check("latency", lat_obs, lat_exp);
        check("busy_cycles", busy_cnt, lat_exp);
        check("hi", hi, exp_hi);
        check("lo", lo, exp_lo);
        check("div_zero", div_zero, exp_dz);
        check("busy_at_done", busy, 1'b0);
        $display("op %s a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d",
                 is_div ? "DIV " : "MULT", oa, ob, hi, lo, div_zero, lat_obs);
        // A start during the done cycle must be dropped.
        start_mult = 1'b1;
        a = $urandom;
        b = $urandom;
        @(posedge clk); #1;
        start_mult = 1'b0;
        check("done_pulse", done, 1'b0);
        check("start_in_done_ignored", busy, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            5:       v = 32'($urandom_range(0, 20)) - 32'd10;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dz", div_zero, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, -5);
        check("mul7_hi", hi, 32'hFFFF_FFFF);
        check("mul7_lo", lo, 32'hFFFF_FFEB);

        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, -5);
        check("minsq_hi", hi, 32'h4000_0000);
        check("minsq_lo", lo, 32'h0000_0000);

        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, -5);
        check("divm7_lo", lo, 32'hFFFF_FFFD);
        check("divm7_hi", hi, 32'hFFFF_FFFF);

        do_op(1'b0, 32'h66, 32'h2AAA_AAAB, -5);
        do_op(1'b1, 32'd100, 32'd0, -5);
        check("dz_hi", hi, 32'h11);
        check("dz_lo", lo, 32'h22);
        check("dz_flag", div_zero, 1'b1);
        do_op(1'b0, 32'd5, 32'd6, -5);
        check("dz_cleared", div_zero, 1'b0);

        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);

        // Reset in the middle of a multiply discards it.
        @(negedge clk);
        a = 32'd1234;
        b = 32'd5678;
        start_mult = 1'b1;
        @(posedge clk); #1;
        start_mult = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_busy", busy, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        exp_hi = '0;
        exp_lo = '0;
        exp_dz = 1'b0;
        do_op(1'b0, 32'd3, 32'd4, -5);
        check("mul34_lo", lo, 32'd12);
        check("mul34_hi", hi, 32'd0);

`ifdef MDU_HILO_WRITE_EN
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        hi_we = 1'b0;
        exp_hi = 32'hDEAD_BEEF;
        check("mthi", hi, 32'hDEAD_BEEF);
        check("mthi_lo_kept", lo, exp_lo);
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        exp_hi = 32'h1357_9BDF;
        exp_lo = 32'h1357_9BDF;
        check("mthilo_hi", hi, exp_hi);
        check("mthilo_lo", lo, exp_lo);
        do_op(1'b0, 32'd9, 32'd9, 6);
`endif

        for (int i = 0; i < 40; i++) begin
            do_op($urandom_range(0, 1) == 1, pick_operand(), pick_operand(),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle signed multiply/divide unit that executes the MULT and DIV instructions and owns the HI/LO registers.
- Sits directly downstream of the control unit, which pulses a start strobe and waits on done.
- The control unit diverts to its zerodiv state on div_zero.
- MFHI/MFLO read hi/lo combinationally from this block through the MemToReg mux.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous active-low reset
- start_mult  input  1  one-cycle request: signed a*b
- start_div  input  1  one-cycle request: signed a/b
- a  input  WIDTH  operand A, from register A (rs)
- b  input  WIDTH  operand B, from register B (rt)
- hi  output  WIDTH  HI register: product upper half, or remainder
- lo  output  WIDTH  LO register: product lower half, or quotient
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; hi/lo hold the new result in the same cycle
- div_zero  output  1  sticky flag: last DIV had b==0

Behaviour:
- Reset: reset==0 at a posedge forces hi=0, lo=0, busy=0, done=0, div_zero=0 and state=IDLE. This applies from any state and aborts any operation in progress; the partial result is discarded.
- States: IDLE, MUL_ITER, DIV_ITER, DIV_FIX, DONE.
- IDLE:
  - A start is accepted at edge N; a and b are latched, and later operand changes are ignored.
  - An accepted start clears div_zero.
  - If start_mult and start_div are both high, start_mult wins.
- MUL_ITER:
  - Radix-2 Booth, one step per cycle.
  - busy=1 from N+1.
  - WIDTH cycles, N+1..N+WIDTH, then DONE.
- DIV_ITER:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - WIDTH cycles, then DIV_FIX.
- DIV_FIX (1 cycle):
  - Quotient is negated if the signs of a and b differ.
  - Remainder takes the sign of a.
  - Quotient truncates toward zero.
- DONE:
  - hi/lo are written, done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - MULT done occurs at N+WIDTH+1 (N+33). DIV done occurs at N+WIDTH+2 (N+34).
- Divide by zero (b==0 at acceptance):
  - No iteration and busy stays 0.
  - done=1 and div_zero=1 at N+1.
  - hi/lo are unchanged.
- Overflow case -2^(WIDTH-1) / -1: lo=0x80000000, hi=0. No flag is raised.
- hi/lo change only in DONE (or via the optional write port). They hold between operations.
- start_* while busy, or during the DONE cycle, is ignored with no side effect.
- The product is the full 2*WIDTH-bit signed result. No overflow exists for MULT.

Optional Feature:
- Macro: MDU_HILO_WRITE_EN.
- Defined:
  - Adds ports hi_we (in, 1), lo_we (in, 1) and wdata (in, WIDTH) for MTHI/MTLO.
  - In IDLE, hi_we / lo_we load wdata into hi / lo at the next edge.
  - Both may be set in the same cycle.
  - Writes are ignored while busy. A same-cycle start takes priority and drops the write.
- Undefined: these ports are absent, and hi/lo are writable only by MULT/DIV.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) -> done at N+33: hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high N+1..N+32.
- MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000; then DIV a=-7, b=2 -> done at N+34: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=100, b=0 with hi=0x11, lo=0x22 -> done and div_zero=1 at N+1, hi=0x11, lo=0x22, busy never high; next accepted MULT clears div_zero.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; start_div pulsed again at N+5 is ignored, and exactly one done pulse occurs.
- MULT started, reset=0 at N+10 -> next cycle: hi=lo=0, busy=0, done=0; MULT 3*4 then yields lo=12, hi=0 at +33.
- With MDU_HILO_WRITE_EN: hi_we=1, wdata=0xDEADBEEF in IDLE -> hi=0xDEADBEEF; lo_we pulsed while busy -> lo unchanged.
